// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU/DMA requesters, the memory bus arbiter and the memory decode.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_r;
  logic        mem_w;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_r, mem_w,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_r, mem_w,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit memory bus between the CPU and DMA requesters.
// Every output is a flop; an access is IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack).
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic PortCpu = 1'b0;
  localparam logic PortDma = 1'b1;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic        mem_r_q, mem_r_d;
  logic        mem_w_q, mem_w_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        pick_dma;

  // On a tie the port that did not win last time gets the bus.
  assign pick_dma = bus.dma_req & (~bus.cpu_req | (last_grant_q == PortCpu));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    mem_r_d      = 1'b0;
    mem_w_d      = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dma_req) begin
          port_d       = pick_dma;
          last_grant_d = pick_dma;
          we_d         = pick_dma ? bus.dma_we    : bus.cpu_we;
          addr_d       = pick_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d      = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          cnt_d        = WaitLoad;
          mem_r_d      = ~we_d;
          mem_w_d      = we_d;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!we_q) begin
            if (port_q == PortDma) dma_rdata_d = bus.mem_rdata;
            else                   cpu_rdata_d = bus.mem_rdata;
          end
          cpu_ack_d = (port_q == PortCpu);
          dma_ack_d = (port_q == PortDma);
        end else begin
          cnt_d   = cnt_q - 4'd1;
          mem_r_d = ~we_q;
          mem_w_d = we_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= PortDma;
      port_q       <= PortCpu;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      dma_rdata_q  <= 8'h00;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      mem_r_q      <= mem_r_d;
      mem_w_q      <= mem_w_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_r     = mem_r_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model that predicts grants, strobes, acks and read data per cycle.
module tb_mem_bus_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter_if bus_w0 ();
  mem_bus_arbiter_if bus_w15 ();

  mem_bus_arbiter #(.WAIT_STATES(WS)) dut     (.clk(clk), .reset(reset), .bus(bus));
  mem_bus_arbiter #(.WAIT_STATES(0))  dut_w0  (.clk(clk), .reset(reset), .bus(bus_w0));
  mem_bus_arbiter #(.WAIT_STATES(15)) dut_w15 (.clk(clk), .reset(reset), .bus(bus_w15));

  // Memory stub behind the main arbiter.
  logic [7:0] ram [256];
  always @(posedge clk) if (bus.mem_w) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  assign bus.mem_rdata     = ram[bus.mem_addr[7:0]];
  assign bus_w0.mem_rdata  = 8'h5A;
  assign bus_w15.mem_rdata = 8'hC3;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: which transaction owns the bus, when it ends, and what it returns.
  int          e         = 0;
  int          free_edge = 0;
  int          g_edge    = 0;
  bit          active    = 1'b0;
  bit          m_port    = 1'b0;
  bit          m_last    = 1'b1;
  bit          m_we      = 1'b0;
  logic [15:0] m_addr    = 16'h0;
  logic [7:0]  m_wdata   = 8'h0;
  logic [7:0]  m_rd [2]  = '{8'h0, 8'h0};
  logic [7:0]  ref_mem [256];
  bit          exp_ack [2] = '{1'b0, 1'b0};

  task automatic model_step();
    exp_ack[0] = 1'b0;
    exp_ack[1] = 1'b0;
    if (reset) begin
      // The stub already took the write strobe on this edge.
      if (active && m_we) ref_mem[m_addr[7:0]] = m_wdata;
      active    = 1'b0;
      m_last    = 1'b1;
      m_we      = 1'b0;
      m_addr    = 16'h0;
      m_wdata   = 8'h0;
      m_rd[0]   = 8'h0;
      m_rd[1]   = 8'h0;
      free_edge = e + 1;
    end else begin
      if (active && e == g_edge + WS + 1) begin
        active = 1'b0;
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        else      m_rd[m_port] = ref_mem[m_addr[7:0]];
        exp_ack[m_port] = 1'b1;
      end
      if (e >= free_edge && (bus.cpu_req || bus.dma_req)) begin
        if (bus.cpu_req && bus.dma_req) m_port = !m_last;
        else                            m_port = bus.dma_req;
        m_last    = m_port;
        m_we      = m_port ? bus.dma_we    : bus.cpu_we;
        m_addr    = m_port ? bus.dma_addr  : bus.cpu_addr;
        m_wdata   = m_port ? bus.dma_wdata : bus.cpu_wdata;
        active    = 1'b1;
        g_edge    = e;
        free_edge = e + WS + 3;
      end
    end
  endtask

  task automatic cmp_cycle();
    check("cpu_ack",   bus.cpu_ack,   exp_ack[0]);
    check("dma_ack",   bus.dma_ack,   exp_ack[1]);
    check("mem_r",     bus.mem_r,     active && !m_we);
    check("mem_w",     bus.mem_w,     active && m_we);
    check("mem_addr",  bus.mem_addr,  m_addr);
    check("mem_wdata", bus.mem_wdata, m_wdata);
    check("cpu_rdata", bus.cpu_rdata, m_rd[0]);
    check("dma_rdata", bus.dma_rdata, m_rd[1]);
  endtask

  // One clock: let the edge happen, then model and compare half a cycle later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    e++;
    model_step();
    cmp_cycle();
  endtask

  task automatic run_until_ack(input int limit, input bit keep, output int port, output int lat,
                               output int rcnt, output int wcnt);
    port = -1;
    lat  = 0;
    rcnt = 0;
    wcnt = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.mem_r) rcnt++;
      if (bus.mem_w) wcnt++;
      if (bus.cpu_ack || bus.dma_ack) begin
        port = bus.dma_ack ? 1 : 0;
        lat  = i;
        if (!keep) begin
          bus.cpu_req = 1'b0;
          bus.dma_req = 1'b0;
        end
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_port(input bit p);
    bit          req;
    bit          granted;
    bit          nreq;
    bit          nwe;
    logic [15:0] na;
    logic [7:0]  nd;
    req     = p ? bus.dma_req : bus.cpu_req;
    granted = active && (m_port == p);
    nreq    = req;
    nwe     = p ? bus.dma_we    : bus.cpu_we;
    na      = p ? bus.dma_addr  : bus.cpu_addr;
    nd      = p ? bus.dma_wdata : bus.cpu_wdata;
    if (exp_ack[p])  nreq = ($urandom_range(0, 1) == 1);
    else if (!req)   nreq = ($urandom_range(0, 2) == 0);
    // Fields may move freely unless a request is waiting to be granted.
    if (exp_ack[p] || !req || granted) begin
      nwe = ($urandom_range(0, 1) == 1);
      na  = 16'($urandom);
      nd  = 8'($urandom);
    end
    if (p) begin
      bus.dma_req = nreq; bus.dma_we = nwe; bus.dma_addr = na; bus.dma_wdata = nd;
    end else begin
      bus.cpu_req = nreq; bus.cpu_we = nwe; bus.cpu_addr = na; bus.cpu_wdata = nd;
    end
  endtask

  int port, lat, rcnt, wcnt;
  int order [4];
  int lat0, lat15, r0, r15, a0, a15;

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    bus_w0.cpu_req = 0; bus_w0.cpu_we = 0; bus_w0.cpu_addr = 0; bus_w0.cpu_wdata = 0;
    bus_w0.dma_req = 0; bus_w0.dma_we = 0; bus_w0.dma_addr = 0; bus_w0.dma_wdata = 0;
    bus_w15.cpu_req = 0; bus_w15.cpu_we = 0; bus_w15.cpu_addr = 0; bus_w15.cpu_wdata = 0;
    bus_w15.dma_req = 0; bus_w15.dma_we = 0; bus_w15.dma_addr = 0; bus_w15.dma_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0]     = 8'hA5;
    ref_mem[0] = 8'hA5;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // CPU read of 0x2000 returning 0xA5.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h2000; bus.cpu_wdata = 8'h11;
    run_until_ack(20, 1'b0, port, lat, rcnt, wcnt);
    check("t1_port", port, 0);
    check("t1_latency", lat, 3);
    check("t1_mem_r_cycles", rcnt, 2);
    check("t1_mem_w_cycles", wcnt, 0);
    check("t1_rdata", bus.cpu_rdata, 8'hA5);
    check("t1_addr", bus.mem_addr, 16'h2000);
    step();

    // DMA write 0x1C00 <- 0x3C.
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h1C00; bus.dma_wdata = 8'h3C;
    run_until_ack(20, 1'b0, port, lat, rcnt, wcnt);
    check("t2_port", port, 1);
    check("t2_mem_w_cycles", wcnt, 2);
    check("t2_mem_r_cycles", rcnt, 0);
    check("t2_wdata", bus.mem_wdata, 8'h3C);
    check("t2_dma_rdata", bus.dma_rdata, 8'h00);
    step();

    // Both held from reset: grants must alternate CPU, DMA, CPU, DMA.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      run_until_ack(20, 1'b1, port, lat, rcnt, wcnt);
      order[i] = port;
    end
    bus.cpu_req = 0; bus.dma_req = 0;
    check("t3_grant0", order[0], 0);
    check("t3_grant1", order[1], 1);
    check("t3_grant2", order[2], 0);
    check("t3_grant3", order[3], 1);
    repeat (2) step();

    // Address changed mid-access must not reach the bus.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h2000;
    step();
    check("t4_addr_a", bus.mem_addr, 16'h2000);
    bus.cpu_addr = 16'h3000;
    step();
    check("t4_addr_b", bus.mem_addr, 16'h2000);
    run_until_ack(20, 1'b0, port, lat, rcnt, wcnt);
    check("t4_addr_done", bus.mem_addr, 16'h2000);
    step();

    // Reset in the second ACCESS cycle abandons the access; next tie goes to CPU.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0040;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("t5_mem_r", bus.mem_r, 1'b0);
    check("t5_cpu_ack", bus.cpu_ack, 1'b0);
    reset = 1'b0;
    bus.cpu_req = 0;
    step();
    check("t5_no_ack", bus.cpu_ack, 1'b0);
    bus.cpu_req = 1; bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0050;
    run_until_ack(20, 1'b0, port, lat, rcnt, wcnt);
    check("t5_tie_port", port, 0);
    repeat (2) step();

    // WAIT_STATES = 0 and 15 builds.
    bus_w0.cpu_req = 1;  bus_w0.cpu_addr = 16'h0100;
    bus_w15.cpu_req = 1; bus_w15.cpu_addr = 16'h0200;
    lat0 = 0; lat15 = 0; r0 = 0; r15 = 0; a0 = 0; a15 = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus_w0.mem_r)  r0++;
      if (bus_w15.mem_r) r15++;
      if (bus_w0.cpu_ack) begin
        a0++;
        if (lat0 == 0) lat0 = i;
        check("w0_rdata", bus_w0.cpu_rdata, 8'h5A);
        bus_w0.cpu_req = 0;
      end
      if (bus_w15.cpu_ack) begin
        a15++;
        if (lat15 == 0) lat15 = i;
        check("w15_rdata", bus_w15.cpu_rdata, 8'hC3);
        bus_w15.cpu_req = 0;
      end
    end
    check("w0_latency", lat0, 2);
    check("w15_latency", lat15, 17);
    check("w0_access_cycles", r0, 1);
    check("w15_access_cycles", r15, 16);
    check("w0_ack_pulses", a0, 1);
    check("w15_ack_pulses", a15, 1);

    // Random traffic from both ports with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        bus.cpu_req = 0;
        bus.dma_req = 0;
      end else begin
        reset = 1'b0;
        drive_port(1'b0);
        drive_port(1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
